fb_scanout: RTL

- Read side of the framebuffer: fetches shaded RGB565 pixels from framebuffer memory and supplies the VGA output stage with one 8:8:8 pixel per accepted request.
- Shaded pixels are packed as {r[4:0], g[5:0], b[4:0]}.
- Prefetches into a small FIFO through a request/grant/return memory port, so memory latency is hidden from the display timing.

---
 rtl/fb_scanout.sv | 106 ++++++++++
 1 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer read side, prefetches RGB565 words into a FIFO and serves 8:8:8 pixels
module fb_scanout #(
    parameter int                H_ACTIVE   = 640,
    parameter int                V_ACTIVE   = 480,
    parameter int                ADDR_W     = 20,
    parameter logic [ADDR_W-1:0] FB_BASE    = '0,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    input  logic              pixel_ready,
    output logic              pixel_valid,
    output logic [7:0]        r_out,
    output logic [7:0]        g_out,
    output logic [7:0]        b_out,
    output logic              frame_done,
    output logic              underflow
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  fetch_idx, pop_idx;
    logic [CNT_W-1:0]  outstanding, fifo_count, in_flight, out_nx;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [15:0]       head;
    logic              active, grant, ret, push, pop, abort, last_pop, restart;

    // Credits count both buffered words and words still in flight, so a
    // grant is only issued when its return is guaranteed a FIFO slot.
    assign active      = state == ACTIVE;
    assign in_flight   = fifo_count + outstanding;
    assign mem_req     = active && fetch_idx < IDX_W'(TOTAL) && in_flight < CNT_W'(FIFO_DEPTH);
    assign mem_addr    = FB_BASE + ADDR_W'(fetch_idx);
    assign grant       = mem_req && mem_gnt;
    assign ret         = mem_rvalid && outstanding != '0;
    assign abort       = active && frame_start;
    assign pixel_valid = active && fifo_count != '0;
    assign push        = active && ret && !abort;
    assign pop         = pixel_valid && pixel_ready && !abort;
    assign last_pop    = pop && pop_idx == IDX_W'(TOTAL - 1);
    assign out_nx      = outstanding + CNT_W'(grant) - CNT_W'(ret);
    assign restart     = (state == IDLE && frame_start) || abort || (state == FLUSH && out_nx == '0);

    // Colour expansion replicates the top bits so full-scale maps to 0xFF.
    assign head  = fifo_mem[rd_ptr];
    assign r_out = pixel_valid ? {head[15:11], head[15:13]} : 8'h00;
    assign g_out = pixel_valid ? {head[10:5], head[10:9]} : 8'h00;
    assign b_out = pixel_valid ? {head[4:0], head[4:2]} : 8'h00;

    // Next state: an abort waits in FLUSH until every in-flight return has drained.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? ACTIVE : IDLE;
            ACTIVE:  state_nx = abort ? ((out_nx != '0) ? FLUSH : ACTIVE) : (last_pop ? IDLE : ACTIVE);
            FLUSH:   state_nx = (out_nx == '0) ? ACTIVE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    // Fetch/pop counters, FIFO pointers and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_idx   <= '0;
            pop_idx     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            frame_done  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            outstanding <= out_nx;
            fetch_idx   <= restart ? '0 : fetch_idx + IDX_W'(grant);
            pop_idx     <= restart ? '0 : pop_idx + IDX_W'(pop);
            wr_ptr      <= abort ? '0 : wr_ptr + PTR_W'(push);
            rd_ptr      <= abort ? '0 : rd_ptr + PTR_W'(pop);
            fifo_count  <= abort ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
            frame_done  <= last_pop && !abort;
            underflow   <= underflow || (active && pixel_ready && fifo_count == '0);
        end
    end

    // FIFO storage; contents are don't-care while empty, outputs are masked.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= mem_rdata;
    end
endmodule
